// File: rtl/shift_issue_if.sv
// shift_issue_if: dispatch, register-file read and issue signals of the shift issue buffer.
interface shift_issue_if #(
    parameter int RB = 2,
    parameter int DW = 3 + (5 + RB) + 64 + 64 + 1
);
    localparam int PW = 5 + RB;
    localparam int IW = 3 + 3 * PW + 66;
    logic          dispat_vaild;
    logic [IW-1:0] dispat_info;
    logic          shift_buffer_full;
    logic [PW-1:0] rs1_raddr, rs2_raddr;
    logic [63:0]   rs1_rdata, rs2_rdata;
    logic          shift_exeparam_vaild;
    logic [DW-1:0] shift_exeparam;
    modport master (
        output dispat_vaild, dispat_info, rs1_rdata, rs2_rdata,
        input  shift_buffer_full, rs1_raddr, rs2_raddr, shift_exeparam_vaild, shift_exeparam
    );
    modport slave (
        input  dispat_vaild, dispat_info, rs1_rdata, rs2_rdata,
        output shift_buffer_full, rs1_raddr, rs2_raddr, shift_exeparam_vaild, shift_exeparam
    );
endinterface

// File: rtl/shift_issue.sv
// shift_issue: in-order issue buffer that waits for operand write-back, then sends shift ops to execution.
module shift_issue #(
    parameter int DP = 4,
    parameter int RB = 2,
    parameter int DW = 3 + (5 + RB) + 64 + 64 + 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  flush,
    input  logic [32*(2**RB)-1:0] wbLog_qout,
    shift_issue_if.slave          bus
);
    localparam int PW = 5 + RB;
    localparam int IW = 3 + 3 * PW + 66;
    localparam int AW = $clog2(DP);
    logic [IW-1:0] mem [DP];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   cnt;
    logic [IW-1:0] head;
    logic [PW-1:0] rs1, rs2;
    logic [63:0]   op1, op2;
    logic          rdy1, rdy2, is_imm, push, issue;
    logic          valid;
    logic [DW-1:0] param;

    assign head   = mem[rd_ptr];
    assign rs1    = head[IW-4-PW -: PW];
    assign rs2    = head[IW-4-2*PW -: PW];
    assign is_imm = head[1];
    // architectural register 0 is hard-wired zero, so it never waits on write-back
    assign rdy1   = rs1[PW-1:RB] == '0 || wbLog_qout[rs1];
    assign rdy2   = rs2[PW-1:RB] == '0 || wbLog_qout[rs2];
    assign op1    = rs1[PW-1:RB] == '0 ? '0 : bus.rs1_rdata;
    assign op2    = is_imm ? head[65:2] : rs2[PW-1:RB] == '0 ? '0 : bus.rs2_rdata;
    assign bus.shift_buffer_full    = cnt == (AW+1)'(DP);
    assign bus.rs1_raddr            = rs1;
    assign bus.rs2_raddr            = rs2;
    assign bus.shift_exeparam_vaild = valid;
    assign bus.shift_exeparam       = param;
    assign push  = bus.dispat_vaild && !bus.shift_buffer_full && !flush;
    assign issue = cnt != '0 && rdy1 && (is_imm || rdy2) && !flush;

    always_ff @(posedge CLK)
        if (push) mem[wr_ptr] <= bus.dispat_info;

    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            param  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr + AW'(issue);
            wr_ptr <= wr_ptr + AW'(push);
            cnt    <= cnt + (AW+1)'(push) - (AW+1)'(issue);
            valid  <= issue;
            if (issue) param <= {head[IW-1 -: 3+PW], op1, op2, head[0]};
        end
endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 Parameters SHALL be: DP, 4, issue-buffer depth (power of 2); DW, `SHIFT_EXEPARAM_DW, packed exeparam width = 3+(5+`RB)+64+64+1.
REQ-002 Ports SHALL be:
  CLK  in  1  clock, all state updates on rising edge.
  RSTn  in  1  asynchronous active-low reset.
  dispat_vaild  in  1  dispatch pushes one shift op.
  dispat_info  in  3+3*(5+`RB)+64+2  {sll, srl, sra, rd0, rs1, rs2, imm[63:0], is_imm, is32w}.
  shift_buffer_full  out  1  buffer holds DP entries; dispatch must stall.
  wbLog_qout  in  32*2^`RB  per-physical-register written-back flag.
  rs1_raddr, rs2_raddr  out  5+`RB each  combinational register-file read addresses (head entry).
  rs1_rdata, rs2_rdata  in  64 each  combinational read data, same cycle.
  shift_exeparam_vaild  out  1  registered issue strobe to shift execution unit.
  shift_exeparam  out  DW  registered {sll, srl, sra, rd0, op1, op2, is32w}, MSB first.
  flush  in  1  pipeline flush.

Function
REQ-003 Buffer SHALL be a DP-entry circular FIFO: read pointer, write pointer (log2 DP bits, wrap DP-1 -> 0), count 0..DP.
REQ-004 shift_buffer_full SHALL be 1 exactly when count == DP, from registered state (no combinational path from dispat_vaild).
REQ-005 Push SHALL occur when dispat_vaild=1, full=0, flush=0; dispat_vaild while full SHALL be ignored (no push, no state change).
REQ-006 Physical index SHALL be {arch[4:0], rename[`RB-1:0]}; ready(r) = 1 if arch==0, else wbLog_qout[r].
REQ-007 Head entry SHALL be issue-ready when count>0 and ready(rs1)=1 and (is_imm=1 or ready(rs2)=1).
REQ-008 Issue SHALL be strictly in order, head only, at most one op per cycle; a non-ready head blocks younger entries.
REQ-009 On issue cycle (ready, flush=0) next edge SHALL load shift_exeparam_vaild=1 and shift_exeparam with op1 = (rs1 arch==0 ? 0 : rs1_rdata), op2 = is_imm ? imm : (rs2 arch==0 ? 0 : rs2_rdata), and pop head.
REQ-010 shift_exeparam_vaild SHALL be 1 for exactly one cycle per issued op; shift_exeparam SHALL hold its last value when valid=0.
REQ-011 Latency SHALL be: push at edge N, operands ready -> valid at edge N+1 earliest (entry visible at head the cycle after push).
REQ-012 Simultaneous push and pop SHALL keep count unchanged, both pointers advance.
REQ-013 Full buffer with issue in same cycle SHALL still reject dispatch (full is state-based).
REQ-014 rs1_raddr/rs2_raddr SHALL reflect head entry fields whenever count>0; value is don't-care when empty.
REQ-015 flush=1 SHALL at next edge: zero count and both pointers, force shift_exeparam_vaild=0, drop any same-cycle push and issue; flush overrides all.
REQ-016 Execution unit has no back-pressure; issue SHALL never wait on a downstream ready.

Reset
REQ-017 RSTn=0 SHALL asynchronously clear pointers, count, shift_exeparam_vaild and shift_exeparam to 0; entry storage need not reset.
REQ-018 After RSTn release, shift_buffer_full=0 and no issue until first push.

Verification
REQ-019 Ready issue: push sll, rs1={3,0}, is_imm=1, imm=4, wbLog bit set, rs1_rdata=0x1 -> next cycle valid=1, op1=0x1, op2=4, sll=1, rd0 as pushed.
REQ-020 Blocked head: push srl with rs2 not written back, then ready sra -> no valid until rs2 bit set; then srl issues, sra issues following cycle, in order.
REQ-021 Full/wrap: push 4 blocked ops -> full=1, 5th push ignored; release all -> 4 consecutive valids; push 4 more -> pointers wrap, order preserved.
REQ-022 x0 operands: rs1 arch=0, rs2 arch=0, wbLog all 0, rdata=0xFFFF... -> issues immediately, op1=0, op2=0.
REQ-023 Flush: 3 entries, head ready, assert flush with dispat_vaild=1 -> next cycle valid=0, count=0, full=0, no later issue of flushed ops.
REQ-024 Async reset mid-operation: RSTn low between edges with valid=1 -> valid and exeparam drop to 0 immediately, buffer empty after release.
